// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//
// Sequential front end for the combinational 16-bit ALU. It accepts 32-bit
// commands over a valid/ready handshake and runs either one ALU pass (narrow)
// or two chained passes (wide ADD/SUB, with carry/borrow propagated from the
// low half into the high half). The captured result and flags are returned over
// a second valid/ready handshake.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid / cmd_ready            command handshake
//   cmd_op, cmd_a, cmd_b             opcode and 32-bit operands
//   cmd_wide, cmd_cin                two-pass request (ADD/SUB only), carry/borrow-in
//   alu_in0, alu_in1, alu_sel        registered ALU operands and opcode
//   alu_carryin, alu_borrowin        registered ALU carry-in / borrow-in
//   alu_out, alu_upper, alu_rem      ALU result, multiply upper half, remainder
//   alu_zero .. alu_dbz              ALU flags
//   rsp_valid / rsp_ready            response handshake
//   rsp_data, rsp_flags              result and {dbz, ovf, borrow, carry, neg, zero}
//   ops_done                         saturating count of completed responses
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic        cmd_wide,
    input  logic        cmd_cin,
    output logic [15:0] alu_in0,
    output logic [15:0] alu_in1,
    output logic [4:0]  alu_sel,
    output logic        alu_carryin,
    output logic        alu_borrowin,
    input  logic [15:0] alu_out,
    input  logic [15:0] alu_upper,
    input  logic [15:0] alu_rem,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_carry,
    input  logic        alu_borrow,
    input  logic        alu_ovf,
    input  logic        alu_dbz,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [5:0]  rsp_flags,
    output logic [15:0] ops_done
);

    // Opcode encodings; these must track opcode.vh.
    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_MUL = 5'd2;
    localparam logic [4:0] ALU_DIV = 5'd3;

    typedef enum logic [1:0] {StIdle, StLo, StHi, StResp} state_e;

    state_e      state_q, state_d;

    // Command state kept across passes; the low halves go straight to the ALU regs.
    logic [4:0]  op_q, op_d;
    logic [15:0] a_hi_q, a_hi_d;
    logic [15:0] b_hi_q, b_hi_d;
    logic        wide_q, wide_d;

    logic [15:0] in0_q, in0_d;
    logic [15:0] in1_q, in1_d;
    logic [4:0]  sel_q, sel_d;
    logic        cin_q, cin_d;
    logic        bin_q, bin_d;

    // data_q[15:0] doubles as lo_res, data_q[31:16] as hi_res / upper / remainder.
    logic [31:0] data_q, data_d;
    logic [5:0]  flags_q, flags_d;
    logic [15:0] ops_q, ops_d;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (cmd_valid) state_d = StLo;
            StLo:   state_d = wide_q ? StHi : StResp;
            StHi:   state_d = StResp;
            StResp: if (rsp_ready) state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        op_d    = op_q;
        a_hi_d  = a_hi_q;
        b_hi_d  = b_hi_q;
        wide_d  = wide_q;
        in0_d   = in0_q;
        in1_d   = in1_q;
        sel_d   = sel_q;
        cin_d   = cin_q;
        bin_d   = bin_q;
        data_d  = data_q;
        flags_d = flags_q;
        ops_d   = ops_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    a_hi_d = cmd_a[31:16];
                    b_hi_d = cmd_b[31:16];
                    wide_d = cmd_wide && ((cmd_op == ALU_ADD) || (cmd_op == ALU_SUB));
                    in0_d  = cmd_a[15:0];
                    in1_d  = cmd_b[15:0];
                    sel_d  = cmd_op;
                    cin_d  = (cmd_op == ALU_ADD) && cmd_cin;
                    bin_d  = (cmd_op == ALU_SUB) && cmd_cin;
                end
            end
            StLo: begin
                if (op_q == ALU_MUL) begin
                    data_d = {alu_upper, alu_out};
                end else if (op_q == ALU_DIV) begin
                    data_d = {alu_rem, alu_out};
                end else begin
                    data_d = {16'h0000, alu_out};
                end
                flags_d = {alu_dbz, alu_ovf, alu_borrow, alu_carry, alu_neg, alu_zero};
                if (wide_q) begin
                    // The carry/borrow seen at this edge is exactly the captured LO value.
                    in0_d = a_hi_q;
                    in1_d = b_hi_q;
                    cin_d = (op_q == ALU_ADD) && alu_carry;
                    bin_d = (op_q == ALU_SUB) && alu_borrow;
                end
            end
            StHi: begin
                data_d[31:16] = alu_out;
                // Zero must cover both halves; dbz cannot occur on ADD/SUB.
                flags_d = {1'b0, alu_ovf, alu_borrow, alu_carry, alu_neg,
                           alu_zero && (data_q[15:0] == 16'h0000)};
            end
            StResp: begin
                if (rsp_ready && (ops_q != 16'hFFFF)) begin
                    ops_d = ops_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_hi_q  <= '0;
            b_hi_q  <= '0;
            wide_q  <= 1'b0;
            in0_q   <= '0;
            in1_q   <= '0;
            sel_q   <= '0;
            cin_q   <= 1'b0;
            bin_q   <= 1'b0;
            data_q  <= '0;
            flags_q <= '0;
            ops_q   <= '0;
        end else begin
            op_q    <= op_d;
            a_hi_q  <= a_hi_d;
            b_hi_q  <= b_hi_d;
            wide_q  <= wide_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            sel_q   <= sel_d;
            cin_q   <= cin_d;
            bin_q   <= bin_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            ops_q   <= ops_d;
        end
    end

    assign alu_in0      = in0_q;
    assign alu_in1      = in1_q;
    assign alu_sel      = sel_q;
    assign alu_carryin  = cin_q;
    assign alu_borrowin = bin_q;
    assign rsp_data     = data_q;
    assign rsp_flags    = flags_q;
    assign ops_done     = ops_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: behavioural 16-bit ALU, 32-bit reference model
// and a response scoreboard fed at command accept, drained by a monitor.
module tb_alu_issue_ctrl;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_DIV = 5'd3;
    localparam logic [4:0] OP_AND = 5'd4;
    localparam logic [4:0] OP_OR  = 5'd5;
    localparam logic [4:0] OP_XOR = 5'd6;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [4:0]  cmd_op;
    logic [31:0] cmd_a, cmd_b;
    logic        cmd_wide, cmd_cin;
    logic [15:0] alu_in0, alu_in1;
    logic [4:0]  alu_sel;
    logic        alu_carryin, alu_borrowin;
    logic [15:0] alu_out, alu_upper, alu_rem;
    logic        alu_zero, alu_neg, alu_carry, alu_borrow, alu_ovf, alu_dbz;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [5:0]  rsp_flags;
    logic [15:0] ops_done;

    int   checks = 0;
    int   errors = 0;
    int   obs_ops = 0;
    bit   done = 0;
    bit   rand_en = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   lat_cnt;
    logic hi_cin, hi_bin;
    logic [15:0] hi_in0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_wide     (cmd_wide),
        .cmd_cin      (cmd_cin),
        .alu_in0      (alu_in0),
        .alu_in1      (alu_in1),
        .alu_sel      (alu_sel),
        .alu_carryin  (alu_carryin),
        .alu_borrowin (alu_borrowin),
        .alu_out      (alu_out),
        .alu_upper    (alu_upper),
        .alu_rem      (alu_rem),
        .alu_zero     (alu_zero),
        .alu_neg      (alu_neg),
        .alu_carry    (alu_carry),
        .alu_borrow   (alu_borrow),
        .alu_ovf      (alu_ovf),
        .alu_dbz      (alu_dbz),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_flags    (rsp_flags),
        .ops_done     (ops_done)
    );

    // Behavioural combinational ALU.
    logic [16:0] alu_t;
    logic [31:0] alu_p;
    always_comb begin
        alu_out = '0; alu_upper = '0; alu_rem = '0;
        alu_carry = 1'b0; alu_borrow = 1'b0; alu_ovf = 1'b0; alu_dbz = 1'b0;
        alu_t = '0; alu_p = '0;
        case (alu_sel)
            OP_ADD: begin
                alu_t = {1'b0, alu_in0} + {1'b0, alu_in1} + {16'd0, alu_carryin};
                alu_out = alu_t[15:0];
                alu_carry = alu_t[16];
                alu_ovf = (alu_in0[15] == alu_in1[15]) && (alu_t[15] != alu_in0[15]);
            end
            OP_SUB: begin
                alu_t = {1'b0, alu_in0} - {1'b0, alu_in1} - {16'd0, alu_borrowin};
                alu_out = alu_t[15:0];
                alu_borrow = alu_t[16];
                alu_ovf = (alu_in0[15] != alu_in1[15]) && (alu_t[15] != alu_in0[15]);
            end
            OP_MUL: begin
                alu_p = {16'd0, alu_in0} * {16'd0, alu_in1};
                alu_out = alu_p[15:0];
                alu_upper = alu_p[31:16];
                alu_ovf = (alu_p[31:16] != 16'd0);
            end
            OP_DIV: begin
                if (alu_in1 == 16'd0) begin
                    alu_dbz = 1'b1;
                end else begin
                    alu_out = alu_in0 / alu_in1;
                    alu_rem = alu_in0 % alu_in1;
                end
            end
            OP_AND: alu_out = alu_in0 & alu_in1;
            OP_OR:  alu_out = alu_in0 | alu_in1;
            OP_XOR: alu_out = alu_in0 ^ alu_in1;
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == 16'd0);
        alu_neg  = alu_out[15];
    end

    // Reference: whole-command result from plain 32-bit / 16-bit arithmetic.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic wide, input logic cin);
        exp_t r;
        logic [32:0] s;
        logic [16:0] t;
        logic [31:0] p;
        logic [15:0] x, y, lo;
        logic carry, borrow, ovf, dbz;
        r = '0; carry = 0; borrow = 0; ovf = 0; dbz = 0; lo = '0;
        x = a[15:0];
        y = b[15:0];
        if (wide && (op == OP_ADD || op == OP_SUB)) begin
            if (op == OP_ADD) begin
                s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                carry = s[32];
                ovf = (a[31] == b[31]) && (s[31] != a[31]);
            end else begin
                s = {1'b0, a} - {1'b0, b} - {32'd0, cin};
                borrow = s[32];
                ovf = (a[31] != b[31]) && (s[31] != a[31]);
            end
            r.data = s[31:0];
            r.flags = {1'b0, ovf, borrow, carry, s[31], s[31:0] == 32'd0};
            return r;
        end
        case (op)
            OP_ADD: begin
                t = {1'b0, x} + {1'b0, y} + {16'd0, cin};
                lo = t[15:0]; carry = t[16];
                ovf = (x[15] == y[15]) && (lo[15] != x[15]);
                r.data = {16'd0, lo};
            end
            OP_SUB: begin
                t = {1'b0, x} - {1'b0, y} - {16'd0, cin};
                lo = t[15:0]; borrow = t[16];
                ovf = (x[15] != y[15]) && (lo[15] != x[15]);
                r.data = {16'd0, lo};
            end
            OP_MUL: begin
                p = {16'd0, x} * {16'd0, y};
                lo = p[15:0]; ovf = (p[31:16] != 16'd0);
                r.data = p;
            end
            OP_DIV: begin
                if (y == 16'd0) begin
                    dbz = 1;
                end else begin
                    lo = x / y;
                    r.data = {x % y, lo};
                end
            end
            OP_AND: begin lo = x & y; r.data = {16'd0, lo}; end
            OP_OR:  begin lo = x | y; r.data = {16'd0, lo}; end
            OP_XOR: begin lo = x ^ y; r.data = {16'd0, lo}; end
            default: r.data = '0;
        endcase
        r.flags = {dbz, ovf, borrow, carry, lo[15], lo == 16'd0};
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called after a posedge; returns #1 after the accepting edge.
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic wide, input logic cin);
        bit acc;
        acc = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_wide = wide; cmd_cin = cin;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
        end
        if (acc) begin
            exp_q.push_back(model(op, a, b, wide, cin));
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: cmd_ready got 0 expected 1");
        end
        #1 cmd_valid = 1'b0;
    endtask

    // Counts negedges until rsp_valid; records ALU drive in the second cycle (HI if wide).
    task automatic wait_rsp(input int lat, input string name);
        lat_cnt = 0;
        do begin
            @(negedge clk);
            lat_cnt++;
            if (lat_cnt == 2) begin
                hi_cin = alu_carryin;
                hi_bin = alu_borrowin;
                hi_in0 = alu_in0;
            end
        end while (!rsp_valid && lat_cnt < 12);
        check(name, 64'(lat_cnt), 64'(lat));
    endtask

    task automatic release_rsp();
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_wide = 1'b0; cmd_cin = 1'b0;
        fork
            begin : main_seq
                logic [31:0] d_snap;
                logic [5:0]  f_snap;
                logic [15:0] ops_snap;
                bit          stable;
                #3;
                check("reset_cmd_ready", cmd_ready, 1);
                check("reset_rsp_valid", rsp_valid, 0);
                check("reset_alu_regs", {alu_in0, alu_in1, alu_sel, alu_carryin, alu_borrowin}, 0);
                check("reset_rsp", {rsp_data, rsp_flags, ops_done}, 0);
                @(posedge clk);
                #1 rst_n = 1'b1;
                @(posedge clk);
                #1;

                send(OP_ADD, 32'h0001_FFFF, 32'h0000_0001, 1'b1, 1'b0);
                wait_rsp(3, "t1_wide_add_latency");
                check("t1_data", rsp_data, 32'h0002_0000);
                check("t1_carry_zero", {rsp_flags[2], rsp_flags[0]}, 2'b00);
                release_rsp();

                send(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
                wait_rsp(3, "t2_latency");
                check("t2_hi_carryin", hi_cin, 1);
                check("t2_data", rsp_data, 32'h0000_0000);
                check("t2_carry_zero", {rsp_flags[2], rsp_flags[0]}, 2'b11);
                release_rsp();

                send(OP_SUB, 32'h0001_0000, 32'h0000_0001, 1'b1, 1'b0);
                wait_rsp(3, "t3_latency");
                check("t3_hi_borrowin", hi_bin, 1);
                check("t3_data", rsp_data, 32'h0000_FFFF);
                check("t3_borrow_neg", {rsp_flags[3], rsp_flags[1]}, 2'b00);
                release_rsp();

                send(OP_MUL, 32'h0000_0100, 32'h0000_0100, 1'b0, 1'b0);
                wait_rsp(2, "t4_mul_latency");
                check("t4_mul_data", rsp_data, 32'h0001_0000);
                release_rsp();

                // Wide flag with a non-ADD/SUB opcode must be ignored.
                send(OP_DIV, 32'h0000_1234, 32'h0000_0000, 1'b1, 1'b1);
                wait_rsp(2, "t5_div_latency");
                check("t5_dbz", rsp_flags[5], 1);
                release_rsp();

                // Backpressure.
                send(OP_XOR, 32'h0000_A5A5, 32'h0000_0F0F, 1'b0, 1'b0);
                wait_rsp(2, "bp_latency");
                d_snap = rsp_data; f_snap = rsp_flags; ops_snap = ops_done;
                stable = 1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (!rsp_valid || cmd_ready || rsp_data !== d_snap || rsp_flags !== f_snap
                        || ops_done !== ops_snap) stable = 0;
                end
                check("bp_hold_stable", stable, 1);
                release_rsp();
                check("bp_ops_step", ops_done, 64'(ops_snap) + 1);

                // Randomized traffic with random response backpressure.
                rand_en = 1;
                for (int n = 0; n < 200; n++) begin
                    logic [31:0] ra, rb;
                    ra = $urandom;
                    rb = $urandom;
                    if ($urandom_range(0, 3) == 0) rb[15:0] = 16'd0;
                    send(5'($urandom_range(0, 6)), ra, rb, 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
                end
                for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
                check("drain_queue_empty", 64'(exp_q.size()), 0);
                rand_en = 0;
                @(posedge clk);
                #1 rsp_ready = 1'b0;
                @(negedge clk);
                check("ops_done_count", ops_done, 64'(obs_ops));

                // Reset while in HI: nothing may come back.
                @(posedge clk);
                #1;
                send(OP_ADD, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
                @(negedge clk);
                @(negedge clk);
                check("rst_hi_reached", alu_in0, 16'h1234);
                rst_n = 1'b0;
                #1;
                check("rst_hi_ctrl", {cmd_ready, rsp_valid}, 2'b10);
                check("rst_hi_alu_regs", {alu_in0, alu_in1, alu_sel, alu_carryin, alu_borrowin}, 0);
                check("rst_hi_rsp", {rsp_data, rsp_flags, ops_done}, 0);
                void'(exp_q.pop_back());
                @(posedge clk);
                #1 rst_n = 1'b1;
                rsp_ready = 1'b1;
                stable = 1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    if (rsp_valid) stable = 0;
                end
                check("rst_no_response", stable, 1);
                check("rst_ops_zero", ops_done, 0);
                rsp_ready = 1'b0;
                done = 1;
            end
            begin : monitor
                while (!done) begin
                    @(negedge clk);
                    if (!done && rst_n && rsp_valid && rsp_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rsp_unexpected: got data %0h expected no response",
                                     rsp_data);
                        end else begin
                            mon_e = exp_q.pop_front();
                            check("sb_rsp_data", rsp_data, mon_e.data);
                            check("sb_rsp_flags", rsp_flags, mon_e.flags);
                            obs_ops++;
                        end
                    end
                end
            end
            begin : ready_gen
                while (!done) begin
                    @(posedge clk);
                    #1;
                    if (rand_en) rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
